// File: rtl/sd_card_pkg.sv
// SD card CMD-line responder: shared constants, enums and CRC7 step.
// Imported by the responder top and its CRC7 helper.
package sd_card_pkg;

  localparam logic [5:0] CMD_GO_IDLE  = 6'd0;
  localparam logic [5:0] CMD_ALL_CID  = 6'd2;
  localparam logic [5:0] CMD_SEND_RCA = 6'd3;
  localparam logic [5:0] CMD_SELECT   = 6'd7;
  localparam logic [5:0] CMD_IF_COND  = 6'd8;
  localparam logic [5:0] CMD_STATUS   = 6'd13;
  localparam logic [5:0] CMD_BLOCKLEN = 6'd16;
  localparam logic [5:0] ACMD_OP_COND = 6'd41;
  localparam logic [5:0] CMD_APP      = 6'd55;

  localparam logic [5:0] R3_INDEX = 6'h3F;
  localparam logic [6:0] R3_CRC   = 7'h7F;

  localparam int unsigned R1_ILLEGAL   = 22;
  localparam int unsigned R1_STATE_LSB = 9;
  localparam int unsigned R1_RDY_DATA  = 8;
  localparam int unsigned R1_APP_CMD   = 5;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_READY = 4'd1,
    ST_IDENT = 4'd2,
    ST_STBY  = 4'd3,
    ST_TRAN  = 4'd4
  } card_state_e;

  typedef enum logic [2:0] {
    RSP_NONE,
    RSP_R1,
    RSP_R3,
    RSP_R6,
    RSP_R7
  } rsp_e;

  // x^7 + x^3 + 1, MSB-first
  function automatic logic [6:0] crc7_next(
    input logic [6:0] crc,
    input logic       din
  );
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 accumulator, one bit per enabled cycle.
// Synchronous clear has priority over enable.
module sd_crc7_serial
  import sd_card_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc_q <= '0;
    end else if (clr) begin
      crc_q <= '0;
    end else if (en) begin
      crc_q <= crc7_next(crc_q, din);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD responder: decodes host commands, answers R1/R3/R6/R7.
// Runs on msoc_clk; sd_sclk and sd_cmd_i are oversampled inputs.
module sd_card_cmd_responder
  import sd_card_pkg::*;
#(
  parameter int unsigned NCR        = 2,
  parameter int unsigned BUSY_POLLS = 3,
  parameter logic        CCS        = 1'b1,
  parameter logic [23:0] OCR_VDD    = 24'hFF8000,
  parameter logic [15:0] RCA        = 16'h1234
) (
  input  logic       msoc_clk,
  input  logic       rstn,
  input  logic       sd_sclk,
  input  logic       sd_cmd_i,
  output logic       sd_cmd_o,
  output logic       sd_cmd_oe,
  output logic       card_ready,
  output logic [3:0] card_state,
  output logic [7:0] crc_err_cnt
);

  typedef enum logic [2:0] {
    S_RX_IDLE,
    S_RX,
    S_CHECK,
    S_WAIT_NCR,
    S_TX
  } fsm_e;

  logic sclk_s1_q, sclk_s2_q;
  logic cmd_s1_q, cmd_s2_q;

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      cmd_s1_q  <= 1'b1;
      cmd_s2_q  <= 1'b1;
    end else begin
      sclk_s1_q <= sd_sclk;
      sclk_s2_q <= sclk_s1_q;
      cmd_s1_q  <= sd_cmd_i;
      cmd_s2_q  <= cmd_s1_q;
    end
  end

  logic rise, fall;
  assign rise = sclk_s1_q & ~sclk_s2_q;
  assign fall = ~sclk_s1_q & sclk_s2_q;

  fsm_e        fsm_q;
  card_state_e state_q;
  rsp_e        rsp_q;
  logic [5:0]  bit_cnt_q;
  logic [6:0]  ncr_cnt_q;
  logic [47:0] rx_sr_q;
  logic [47:0] tx_sr_q;
  logic [7:0]  poll_q;
  logic [7:0]  err_q;
  logic        app_cmd_q;
  logic        illegal_q;
  logic        ready_q;
  logic        cmd_o_q;
  logic        oe_q;

  logic [6:0] rx_crc, tx_crc;

  logic [5:0]  idx;
  logic [31:0] arg;
  logic        frame_ok;
  logic        ocr_ready;
  logic        unused_arg;

  assign idx        = rx_sr_q[45:40];
  assign arg        = rx_sr_q[39:8];
  assign unused_arg = ^arg[15:12];
  assign ocr_ready  = poll_q >= 8'(BUSY_POLLS);
  assign frame_ok   = !rx_sr_q[47] && rx_sr_q[46]
                   && rx_sr_q[0]
                   && (rx_crc == rx_sr_q[7:1]);

  // Transmit bit: CRC field is taken live from the TX CRC except for R3
  logic [2:0] crc_sel;
  logic       in_crc;
  logic       tx_bit;
  logic       tx_go;

  assign crc_sel = 3'(6'd46 - bit_cnt_q);
  assign in_crc  = (bit_cnt_q >= 6'd40)
                && (bit_cnt_q < 6'd47);
  assign tx_bit  = (in_crc && rsp_q != RSP_R3)
                 ? tx_crc[crc_sel] : tx_sr_q[47];
  assign tx_go   = fall && (
    (fsm_q == S_WAIT_NCR && ncr_cnt_q == 7'(NCR - 1))
    || (fsm_q == S_TX && bit_cnt_q != 6'd48));

  sd_crc7_serial u_rx_crc (
    .clk  (msoc_clk),
    .rstn (rstn),
    .clr  (fsm_q == S_RX_IDLE),
    .en   (fsm_q == S_RX && rise && bit_cnt_q < 6'd40),
    .din  (cmd_s2_q),
    .crc  (rx_crc)
  );

  sd_crc7_serial u_tx_crc (
    .clk  (msoc_clk),
    .rstn (rstn),
    .clr  (fsm_q == S_CHECK),
    .en   (tx_go && bit_cnt_q < 6'd40),
    .din  (tx_sr_q[47]),
    .crc  (tx_crc)
  );

  rsp_e        dec_rsp;
  card_state_e dec_state;
  logic [5:0]  dec_idx;
  logic [31:0] dec_payload;
  logic [31:0] r1;
  logic [7:0]  dec_poll;
  logic        dec_app;
  logic        dec_illegal;
  logic        dec_ready;

  // R1 reports the state held when the command arrived
  always_comb begin
    r1 = '0;
    r1[R1_ILLEGAL] = illegal_q;
    r1[R1_STATE_LSB +: 4] = state_q;
    r1[R1_RDY_DATA] = 1'b1;
    dec_rsp     = RSP_NONE;
    dec_state   = state_q;
    dec_idx     = idx;
    dec_payload = '0;
    dec_poll    = poll_q;
    dec_app     = 1'b0;
    dec_illegal = illegal_q;
    dec_ready   = ready_q;
    unique case (1'b1)
      idx == CMD_GO_IDLE: begin
        dec_state = ST_IDLE;
        dec_poll  = '0;
        dec_ready = 1'b0;
      end
      idx == CMD_IF_COND: begin
        dec_rsp     = RSP_R7;
        dec_payload = {20'h0, arg[11:0]};
      end
      idx == CMD_APP: begin
        dec_rsp     = RSP_R1;
        dec_app     = 1'b1;
        dec_payload = r1;
        dec_payload[R1_APP_CMD] = 1'b1;
        dec_illegal = 1'b0;
      end
      (idx == ACMD_OP_COND) && app_cmd_q: begin
        dec_rsp     = RSP_R3;
        dec_idx     = R3_INDEX;
        dec_payload = {ocr_ready, CCS, 6'h0, OCR_VDD};
        if (ocr_ready) begin
          dec_state = ST_READY;
          dec_ready = 1'b1;
        end else begin
          dec_poll = poll_q + 8'd1;
        end
      end
      idx == CMD_ALL_CID: begin
        dec_state = ST_IDENT;
      end
      idx == CMD_SEND_RCA: begin
        dec_rsp     = RSP_R6;
        dec_payload = {RCA, 16'h0};
        dec_state   = ST_STBY;
      end
      idx == CMD_SELECT: begin
        dec_rsp     = RSP_R1;
        dec_payload = r1;
        dec_illegal = 1'b0;
        if (arg[31:16] == RCA) dec_state = ST_TRAN;
      end
      (idx == CMD_STATUS) || (idx == CMD_BLOCKLEN): begin
        dec_rsp     = RSP_R1;
        dec_payload = r1;
        dec_illegal = 1'b0;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      fsm_q     <= S_RX_IDLE;
      state_q   <= ST_IDLE;
      rsp_q     <= RSP_NONE;
      bit_cnt_q <= '0;
      ncr_cnt_q <= '0;
      rx_sr_q   <= '0;
      tx_sr_q   <= '1;
      poll_q    <= '0;
      err_q     <= '0;
      app_cmd_q <= 1'b0;
      illegal_q <= 1'b0;
      ready_q   <= 1'b0;
      cmd_o_q   <= 1'b1;
      oe_q      <= 1'b0;
    end else begin
      unique case (fsm_q)
        S_RX_IDLE: begin
          if (rise && !cmd_s2_q) begin
            rx_sr_q   <= '0;
            bit_cnt_q <= 6'd1;
            fsm_q     <= S_RX;
          end
        end
        S_RX: begin
          if (rise) begin
            rx_sr_q   <= {rx_sr_q[46:0], cmd_s2_q};
            bit_cnt_q <= bit_cnt_q + 6'd1;
            if (bit_cnt_q == 6'd47) fsm_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          bit_cnt_q <= '0;
          ncr_cnt_q <= '0;
          if (!frame_ok) begin
            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
            fsm_q <= S_RX_IDLE;
          end else begin
            state_q   <= dec_state;
            poll_q    <= dec_poll;
            app_cmd_q <= dec_app;
            illegal_q <= dec_illegal;
            ready_q   <= dec_ready;
            rsp_q     <= dec_rsp;
            tx_sr_q   <= {2'b00, dec_idx, dec_payload,
                          R3_CRC, 1'b1};
            fsm_q     <= (dec_rsp == RSP_NONE)
                       ? S_RX_IDLE : S_WAIT_NCR;
          end
        end
        S_WAIT_NCR: begin
          if (tx_go) begin
            cmd_o_q   <= tx_bit;
            oe_q      <= 1'b1;
            tx_sr_q   <= {tx_sr_q[46:0], 1'b1};
            bit_cnt_q <= 6'd1;
            fsm_q     <= S_TX;
          end else if (fall) begin
            ncr_cnt_q <= ncr_cnt_q + 7'd1;
          end
        end
        S_TX: begin
          if (tx_go) begin
            cmd_o_q   <= tx_bit;
            tx_sr_q   <= {tx_sr_q[46:0], 1'b1};
            bit_cnt_q <= bit_cnt_q + 6'd1;
          end else if (fall) begin
            cmd_o_q <= 1'b1;
            oe_q    <= 1'b0;
            fsm_q   <= S_RX_IDLE;
          end
        end
        default: fsm_q <= S_RX_IDLE;
      endcase
    end
  end

  assign sd_cmd_o    = cmd_o_q;
  assign sd_cmd_oe   = oe_q;
  assign card_ready  = ready_q;
  assign card_state  = state_q;
  assign crc_err_cnt = err_q;

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Scoreboard bench for sd_card_cmd_responder: host driver on sd_cmd_i,
// response monitor on sd_cmd_o/sd_cmd_oe checked against a queue.
module tb_sd_card_cmd_responder;

  localparam int NCR = 2;

  logic       msoc_clk = 1'b0;
  logic       sd_sclk  = 1'b0;
  logic       rstn     = 1'b0;
  logic       sd_cmd_i = 1'b1;
  logic       sd_cmd_o;
  logic       sd_cmd_oe;
  logic       card_ready;
  logic [3:0] card_state;
  logic [7:0] crc_err_cnt;

  int checks   = 0;
  int failures = 0;

  logic [47:0] exp_q[$];
  logic [47:0] exp_f;
  logic [47:0] cap;
  int rise_no    = 0;
  int end_rise   = 0;
  int rsp_starts = 0;
  int nbits      = 0;
  bit busy       = 1'b0;

  localparam logic [47:0] F_CMD0  = 48'h40_0000_0000_95;
  localparam logic [47:0] F_CMD8  = 48'h48_0000_01AA_87;
  localparam logic [47:0] F_R7    = 48'h08_0000_01AA_13;
  localparam logic [47:0] F_BAD8A = 48'h48_0000_01AA_86;
  localparam logic [47:0] F_BAD8B = 48'h48_0000_01AA_89;

  always #5 msoc_clk = ~msoc_clk;
  always #40 sd_sclk = ~sd_sclk;

  sd_card_cmd_responder #(
    .NCR        (NCR),
    .BUSY_POLLS (3),
    .CCS        (1'b1),
    .OCR_VDD    (24'hFF8000),
    .RCA        (16'h1234)
  ) dut (
    .msoc_clk    (msoc_clk),
    .rstn        (rstn),
    .sd_sclk     (sd_sclk),
    .sd_cmd_i    (sd_cmd_i),
    .sd_cmd_o    (sd_cmd_o),
    .sd_cmd_oe   (sd_cmd_oe),
    .card_ready  (card_ready),
    .card_state  (card_state),
    .crc_err_cnt (crc_err_cnt)
  );

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] mkcmd(
    input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, crc7(h), 1'b1};
  endfunction

  function automatic logic [47:0] mkrsp(
    input logic [5:0] idx, input logic [31:0] pl);
    logic [39:0] h;
    h = {2'b00, idx, pl};
    return {h, crc7(h), 1'b1};
  endfunction

  function automatic logic [47:0] mkr3(input logic [31:0] ocr);
    return {2'b00, 6'h3F, ocr, 7'h7F, 1'b1};
  endfunction

  task automatic check(input string name,
                       input logic [47:0] act,
                       input logic [47:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Response monitor: samples the card output on host clock rises
  always @(posedge sd_sclk) begin
    rise_no++;
    if (!rstn) begin
      busy  = 1'b0;
      nbits = 0;
    end else if (busy) begin
      cap = {cap[46:0], sd_cmd_o};
      nbits++;
      if (nbits == 48) begin
        busy = 1'b0;
        check("rsp_frame", cap, exp_f);
      end
    end else if (sd_cmd_oe === 1'b1 && sd_cmd_o === 1'b0) begin
      rsp_starts++;
      check("rsp_latency", 48'(rise_no - end_rise), 48'(NCR));
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got start bit expected none");
        exp_f = 'x;
      end else begin
        exp_f = exp_q.pop_front();
      end
      cap   = '0;
      nbits = 1;
      busy  = 1'b1;
    end
  end

  task automatic send(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge sd_sclk);
      sd_cmd_i = f[i];
    end
    @(posedge sd_sclk);
    #1;
    end_rise = rise_no;
    @(negedge sd_sclk);
    sd_cmd_i = 1'b1;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge sd_sclk);
      #1;
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("rsp_done", 48'(ok), 48'd1);
    if (!ok) exp_q.delete();
    @(posedge sd_sclk);
    #1;
    check("oe_release", 48'(sd_cmd_oe), 48'd0);
  endtask

  task automatic cmd_rsp(input logic [47:0] f,
                         input logic [47:0] r);
    send(f);
    exp_q.push_back(r);
    wait_done();
  endtask

  task automatic cmd_none(input logic [47:0] f);
    int s;
    s = rsp_starts;
    send(f);
    repeat (10) @(posedge sd_sclk);
    #1;
    check("no_rsp", 48'(rsp_starts), 48'(s));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit hit;
    #100;
    check("rst_cmd_o", 48'(sd_cmd_o), 48'd1);
    check("rst_oe", 48'(sd_cmd_oe), 48'd0);
    check("rst_ready", 48'(card_ready), 48'd0);
    check("rst_state", 48'(card_state), 48'd0);
    check("rst_err", 48'(crc_err_cnt), 48'd0);
    @(negedge msoc_clk);
    rstn = 1'b1;
    repeat (4) @(posedge sd_sclk);

    cmd_none(F_CMD0);
    cmd_rsp(F_CMD8, F_R7);
    check("state_idle", 48'(card_state), 48'd0);

    for (int i = 0; i < 4; i++) begin
      cmd_rsp(mkcmd(6'd55, 32'h0), mkrsp(6'd55, 32'h120));
      cmd_rsp(mkcmd(6'd41, 32'h40FF8000),
              mkr3(i < 3 ? 32'h40FF8000 : 32'hC0FF8000));
      check("ready_poll", 48'(card_ready), 48'(i == 3));
    end
    check("state_ready", 48'(card_state), 48'd1);

    cmd_none(F_BAD8A);
    check("crc_err_1", 48'(crc_err_cnt), 48'd1);
    cmd_none(F_BAD8B);
    check("crc_err_2", 48'(crc_err_cnt), 48'd2);
    cmd_rsp(F_CMD8, F_R7);

    cmd_none(mkcmd(6'd5, 32'h0));
    cmd_rsp(mkcmd(6'd13, 32'h0), mkrsp(6'd13, 32'h00400300));
    cmd_rsp(mkcmd(6'd13, 32'h0), mkrsp(6'd13, 32'h00000300));
    check("crc_err_keep", 48'(crc_err_cnt), 48'd2);

    cmd_none(mkcmd(6'd2, 32'h0));
    check("state_ident", 48'(card_state), 48'd2);
    cmd_rsp(mkcmd(6'd3, 32'h0), mkrsp(6'd3, 32'h12340000));
    check("state_stby", 48'(card_state), 48'd3);
    cmd_rsp(mkcmd(6'd7, 32'h12340000),
            mkrsp(6'd7, 32'h00000700));
    check("state_tran", 48'(card_state), 48'd4);

    send(F_CMD8);
    exp_q.push_back(F_R7);
    hit = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge sd_sclk);
      #1;
      if (busy && nbits == 20) begin
        hit = 1'b1;
        break;
      end
    end
    check("tx_bit20_seen", 48'(hit), 48'd1);
    rstn = 1'b0;
    #1;
    check("midrst_oe", 48'(sd_cmd_oe), 48'd0);
    check("midrst_cmd_o", 48'(sd_cmd_o), 48'd1);
    check("midrst_state", 48'(card_state), 48'd0);
    check("midrst_err", 48'(crc_err_cnt), 48'd0);
    exp_q.delete();
    repeat (2) @(posedge sd_sclk);
    @(negedge msoc_clk);
    rstn = 1'b1;
    repeat (3) @(posedge sd_sclk);

    cmd_none(F_CMD0);
    cmd_rsp(F_CMD8, F_R7);

    check("queue_empty", 48'(exp_q.size()), 48'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
